// File: rtl/aes_dec_key_sequencer_pkg.sv
// AES-128 constants, S-box/Rcon helpers and the key sequencer state type.
// Purely combinational helpers, no latency.
// No flow control here; consumers own backpressure.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int KEY_W  = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } kseq_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constant for rounds 1..10; anything else yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)): rotate left by one byte, then S-box each byte.
    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] rw;
        rw = {w[23:0], w[31:24]};
        return {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
    endfunction

endpackage

// File: rtl/aes_dec_key_sequencer_if.sv
// Key-stream interface between the key sequencer and its start/consumer side.
// No latency; wires only.
// o_Valid/i_Ready handshake on the round-key stream; o_Err exists only with KSEQ_SELFCHECK_EN.
interface aes_dec_key_sequencer_if;
    import aes_pkg::*;

    logic              i_Start;
    logic [KEY_W-1:0]  i_Key;
    logic              i_Ready;
    logic              o_Valid;
    logic [KEY_W-1:0]  o_Key;
    logic [3:0]        o_Round;
    logic              o_Busy;
    logic              o_Done;
`ifdef KSEQ_SELFCHECK_EN
    logic              o_Err;
`endif

    modport slave (
        input  i_Start, i_Key, i_Ready,
        output o_Valid, o_Key, o_Round, o_Busy, o_Done
`ifdef KSEQ_SELFCHECK_EN
        , output o_Err
`endif
    );

    modport master (
        output i_Start, i_Key, i_Ready,
        input  o_Valid, o_Key, o_Round, o_Busy, o_Done
`ifdef KSEQ_SELFCHECK_EN
        , input o_Err
`endif
    );

endinterface

// File: rtl/aes_dec_key_sequencer_key_step.sv
// One AES-128 key-expansion step, forward (i_dir=0) or inverse (i_dir=1).
// Combinational, zero latency.
// No flow control; the caller decides when to register the result.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] i_key,
    input  logic [3:0]       i_round,
    input  logic             i_dir,
    output logic [KEY_W-1:0] o_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_f0, w_f1, w_f2, w_f3;
    logic [31:0] w_i0, w_i1, w_i2, w_i3;
    logic [31:0] w_rc;

    assign {w_w0, w_w1, w_w2, w_w3} = i_key;
    assign w_rc = {rcon(i_round), 24'h0};

    // Forward step rk(r-1) -> rk(r) and inverse step rk(r) -> rk(r-1); i_round is r in both.
    always_comb begin
        w_f0 = w_w0 ^ sub_rot_word(w_w3) ^ w_rc;
        w_f1 = w_w1 ^ w_f0;
        w_f2 = w_w2 ^ w_f1;
        w_f3 = w_w3 ^ w_f2;

        w_i3 = w_w3 ^ w_w2;
        w_i2 = w_w2 ^ w_w1;
        w_i1 = w_w1 ^ w_w0;
        w_i0 = w_w0 ^ sub_rot_word(w_i3) ^ w_rc;

        o_key = i_dir ? {w_i0, w_i1, w_i2, w_i3} : {w_f0, w_f1, w_f2, w_f3};
    end

endmodule

// File: rtl/aes_dec_key_sequencer.sv
// AES-128 decryption key sequencer: expands forward to rk10, then streams rk10..rk0 by inverse expansion.
// Latency: first key valid 10 cycles after the Start edge, then one key per cycle while i_Ready is high.
// i_Ready low holds o_Key/o_Round indefinitely; optional KSEQ_SELFCHECK_EN adds sticky o_Err on rk0 mismatch.
module aes_dec_key_sequencer #(
    parameter int NR    = aes_pkg::AES_NR,
    parameter int KEY_W = aes_pkg::KEY_W
) (
    input  logic                    Clk,
    input  logic                    Rst,
    aes_dec_key_sequencer_if.slave  bus
);
    import aes_pkg::*;

    kseq_state_t      r_state;
    kseq_state_t      w_state_nxt;
    logic [KEY_W-1:0] r_key;
    logic [3:0]       r_ctr;
    logic             w_hs;
    logic             w_step_dir;
    logic [3:0]       w_step_round;
    logic [KEY_W-1:0] w_step_key;

    assign w_hs = (r_state == EMIT) && bus.i_Ready;

    // The single step instance walks forward during FWD and backward during EMIT.
    assign w_step_dir   = (r_state == EMIT);
    assign w_step_round = (r_state == FWD) ? (r_ctr + 4'd1) : r_ctr;

    aes_key_step u_step (
        .i_key   (r_key),
        .i_round (w_step_round),
        .i_dir   (w_step_dir),
        .o_key   (w_step_key)
    );

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: start only from IDLE, leave FWD once rk10 is formed, finish on the rk0 handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.i_Start) w_state_nxt = FWD;
            FWD:     if (r_ctr == 4'(NR - 1)) w_state_nxt = EMIT;
            EMIT:    if (w_hs && (r_ctr == 4'd0)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Key register and round counter: load, expand forward, then regenerate backwards per transfer.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_key <= '0;
            r_ctr <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_Start) begin
                        r_key <= bus.i_Key;
                        r_ctr <= 4'd0;
                    end
                end
                FWD: begin
                    r_key <= w_step_key;
                    r_ctr <= r_ctr + 4'd1;
                end
                EMIT: begin
                    // Round 0 is terminal: the counter never decrements past it.
                    if (w_hs && (r_ctr != 4'd0)) begin
                        r_key <= w_step_key;
                        r_ctr <= r_ctr - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_Valid = (r_state == EMIT);
    assign bus.o_Key   = r_key;
    assign bus.o_Round = r_ctr;
    assign bus.o_Busy  = (r_state != IDLE);
    assign bus.o_Done  = (r_state == DONE);

`ifdef KSEQ_SELFCHECK_EN
    logic [KEY_W-1:0] r_shadow;
    logic             r_err;

    // Shadow of the accepted key; rk0 must reproduce it, otherwise flag a sticky error.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_shadow <= '0;
            r_err    <= 1'b0;
        end else if ((r_state == IDLE) && bus.i_Start) begin
            r_shadow <= bus.i_Key;
            r_err    <= 1'b0;
        end else if (w_hs && (r_ctr == 4'd0) && (r_key != r_shadow)) begin
            r_err    <= 1'b1;
        end
    end

    assign bus.o_Err = r_err;
`endif

endmodule

// File: tb/tb_aes_dec_key_sequencer.sv
// Directed bench for the AES-128 decryption key sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
// Covers reset, two reference keys, stalls, ignored starts, mid-stream reset and the optional self-check.
module tb_aes_dec_key_sequencer;

    localparam logic [127:0] K1     = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] K1_R10 = 128'h28FDDEF86DA4244ACCC0A4FE3B316F26;
    localparam logic [127:0] K1_R1  = 128'hE232FCF191129188B159E4E6D679A293;
    localparam logic [127:0] JUNK   = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

    localparam logic [127:0] FIPS_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic Clk;
    logic Rst;
    int   checks   = 0;
    int   failures = 0;
    logic [127:0] got_key [11];
    int   n_fwd;
    int   n_xfer;

`ifdef KSEQ_SELFCHECK_EN
    bit   corrupt_en = 1'b0;
`endif

    aes_dec_key_sequencer_if bus ();

    aes_dec_key_sequencer dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_k(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse Start with key at a falling edge, then count edges until o_Valid rises.
    task automatic start_fwd(input logic [127:0] key, input bit pulse, output int n);
        bus.i_Key   = key;
        bus.i_Start = 1'b1;
        @(negedge Clk);
        bus.i_Start = 1'b0;
        bus.i_Key   = ~key;
        chk_i("fwd_busy", int'(bus.o_Busy), 1);
        chk_i("fwd_valid0", int'(bus.o_Valid), 0);
        n = 0;
        while (!bus.o_Valid && n < 40) begin
            if (pulse && n == 3) begin
                bus.i_Start = 1'b1;
                bus.i_Key   = JUNK;
            end else begin
                bus.i_Start = 1'b0;
            end
            @(negedge Clk);
            n++;
        end
        bus.i_Start = 1'b0;
    endtask

    // Consume rk10..rk0, optionally stalling once, pulsing Start, checking FIPS keys inline.
    task automatic emit_all(input int stall_round, input int stall_len, input bit pulse,
                            input bit fips, output int n);
        int r;
        n = 0;
        bus.i_Ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            r = 10 - k;
            chk_i("emit_valid", int'(bus.o_Valid), 1);
            chk_i("emit_round", int'(bus.o_Round), r);
            got_key[r] = bus.o_Key;
            if (fips) chk_k("emit_fips_key", bus.o_Key, FIPS_RK[r]);
            if (r == stall_round && stall_len > 0) begin
                bus.i_Ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge Clk);
                    chk_i("stall_valid", int'(bus.o_Valid), 1);
                    chk_i("stall_round", int'(bus.o_Round), r);
                    chk_k("stall_key", bus.o_Key, FIPS_RK[r]);
                end
                bus.i_Ready = 1'b1;
            end
`ifdef KSEQ_SELFCHECK_EN
            if (corrupt_en && r == 5) force dut.r_key = JUNK;
`endif
            bus.i_Start = (pulse && r == 6);
            bus.i_Key   = JUNK;
            @(negedge Clk);
            n++;
        end
        bus.i_Start = 1'b0;
        chk_i("done_pulse", int'(bus.o_Done), 1);
        chk_i("done_valid0", int'(bus.o_Valid), 0);
        chk_i("done_busy", int'(bus.o_Busy), 1);
`ifdef KSEQ_SELFCHECK_EN
        if (corrupt_en) release dut.r_key;
`endif
        bus.i_Start = pulse;
        @(negedge Clk);
        bus.i_Start = 1'b0;
        chk_i("done_once", int'(bus.o_Done), 0);
        chk_i("idle_busy0", int'(bus.o_Busy), 0);
        @(negedge Clk);
        chk_i("idle_stays", int'(bus.o_Busy), 0);
    endtask

    initial begin
        int g;
        Rst         = 1'b1;
        bus.i_Start = 1'b0;
        bus.i_Key   = '0;
        bus.i_Ready = 1'b0;
        #2;
        chk_i("rst_valid", int'(bus.o_Valid), 0);
        chk_i("rst_busy", int'(bus.o_Busy), 0);
        chk_i("rst_done", int'(bus.o_Done), 0);
        chk_k("rst_key", bus.o_Key, 128'h0);
        chk_i("rst_round", int'(bus.o_Round), 0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        // Test 1: reference key, ready always high.
        start_fwd(K1, 1'b0, n_fwd);
        chk_i("t1_fwd_edges", n_fwd, 10);
        emit_all(-1, 0, 1'b0, 1'b0, n_xfer);
        chk_k("t1_rk10", got_key[10], K1_R10);
        chk_k("t1_rk1", got_key[1], K1_R1);
        chk_k("t1_rk0", got_key[0], K1);

        // Test 2: FIPS-197 key, all round keys, one transfer per cycle.
        start_fwd(FIPS_RK[0], 1'b0, n_fwd);
        chk_i("t2_fwd_edges", n_fwd, 10);
        emit_all(-1, 0, 1'b0, 1'b1, n_xfer);
        chk_i("t2_xfer_cycles", n_xfer, 11);

        // Test 3: five-cycle stall at round 7.
        start_fwd(FIPS_RK[0], 1'b0, n_fwd);
        emit_all(7, 5, 1'b0, 1'b1, n_xfer);
        chk_i("t3_xfers", n_xfer, 11);

        // Test 4: Start pulses in FWD, EMIT and DONE are ignored.
        start_fwd(K1, 1'b1, n_fwd);
        chk_i("t4_fwd_edges", n_fwd, 10);
        emit_all(-1, 0, 1'b1, 1'b0, n_xfer);
        chk_k("t4_rk10", got_key[10], K1_R10);
        chk_k("t4_rk1", got_key[1], K1_R1);
        chk_k("t4_rk0", got_key[0], K1);

        // Test 5: reset while emitting round 4, then a clean schedule.
        start_fwd(K1, 1'b0, n_fwd);
        bus.i_Ready = 1'b1;
        g = 0;
        while (bus.o_Round != 4'd4 && g < 20) begin
            @(negedge Clk);
            g++;
        end
        chk_i("t5_reach_r4", int'(bus.o_Round), 4);
        bus.i_Ready = 1'b0;
        Rst = 1'b1;
        #1;
        chk_i("t5_rst_valid", int'(bus.o_Valid), 0);
        chk_i("t5_rst_busy", int'(bus.o_Busy), 0);
        chk_i("t5_rst_done", int'(bus.o_Done), 0);
        chk_k("t5_rst_key", bus.o_Key, 128'h0);
        chk_i("t5_rst_round", int'(bus.o_Round), 0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk_i("t5_idle_after", int'(bus.o_Busy), 0);
        start_fwd(FIPS_RK[0], 1'b0, n_fwd);
        chk_i("t5_fwd_edges", n_fwd, 10);
        emit_all(-1, 0, 1'b0, 1'b1, n_xfer);

`ifdef KSEQ_SELFCHECK_EN
        // Test 6: corrupted key register must raise o_Err; a new Start clears it.
        chk_i("t6_err_clean", int'(bus.o_Err), 0);
        corrupt_en = 1'b1;
        start_fwd(FIPS_RK[0], 1'b0, n_fwd);
        emit_all(-1, 0, 1'b0, 1'b0, n_xfer);
        corrupt_en = 1'b0;
        chk_i("t6_err_set", int'(bus.o_Err), 1);
        start_fwd(K1, 1'b0, n_fwd);
        chk_i("t6_err_cleared", int'(bus.o_Err), 0);
        emit_all(-1, 0, 1'b0, 1'b0, n_xfer);
        chk_k("t6_rk0", got_key[0], K1);
        chk_i("t6_err_stays0", int'(bus.o_Err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
